// File: rtl/cpsr_cond_stage.sv
// Execute-to-writeback stage: ARM condition evaluation, CPSR flag state,
// one-entry writeback register and saturating annulled-instruction counter.
module cpsr_cond_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [3:0]            ex_cond,
  input  logic [4:0]            ex_op,
  input  logic                  ex_setflags,
  input  logic [3:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [3:0]            ex_flags,
  input  logic                  ex_shift_carry,
  input  logic                  flush,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [3:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic                  wb_we,
  output logic                  cond_pass,
  output logic [3:0]            cpsr_flags,
  output logic [CNT_WIDTH-1:0]  annul_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic       fv, fn, fc, fz;
  logic       is_arith;
  logic       is_cmp;
  logic       accept;
  logic       upd_flags;
  logic [3:0] nxt_flags;

  assign {fv, fn, fc, fz} = cpsr_flags;

  always_comb begin
    cond_pass = 1'b0;
    unique case (ex_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc & !fz;
      4'h9: cond_pass = !fc | fz;
      4'ha: cond_pass = (fn == fv);
      4'hb: cond_pass = (fn != fv);
      4'hc: cond_pass = !fz & (fn == fv);
      4'hd: cond_pass = fz | (fn != fv);
      4'he: cond_pass = 1'b1;
      4'hf: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    is_arith = 1'b0;
    case (ex_op)
      5'b00010, 5'b00011, 5'b00100,
      5'b01010, 5'b01011: is_arith = 1'b1;
      default:            is_arith = 1'b0;
    endcase
  end

  assign is_cmp    = (ex_op[4:2] == 3'b010);
  assign ex_ready  = !reset & (!wb_valid | wb_ready);
  assign accept    = ex_valid & ex_ready & !flush;
  assign upd_flags = accept & cond_pass & (ex_setflags | is_cmp);

  // Logical ops keep V and take C from the shifter.
  assign nxt_flags = is_arith ? ex_flags
                   : {fv, ex_flags[2], ex_shift_carry, ex_flags[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_result   <= '0;
      cpsr_flags  <= 4'b0000;
      annul_count <= '0;
    end else begin
      if (accept) begin
        wb_valid  <= 1'b1;
        wb_rd     <= ex_rd;
        wb_result <= ex_result;
        wb_we     <= cond_pass & !is_cmp;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
      end
      if (upd_flags)
        cpsr_flags <= nxt_flags;
      if (accept && !cond_pass && annul_count != CNT_MAX)
        annul_count <= annul_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cpsr_cond_stage.sv
// Scoreboard bench for cpsr_cond_stage: wb entries queued on accept,
// compared on retire; flags and annul count tracked by a reference model.
module tb_cpsr_cond_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_cond;
  logic [4:0]  ex_op;
  logic        ex_setflags;
  logic [3:0]  ex_rd;
  logic [31:0] ex_result;
  logic [3:0]  ex_flags;
  logic        ex_shift_carry;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_we;
  logic        cond_pass;
  logic [3:0]  cpsr_flags;
  logic [15:0] annul_count;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] res;
    logic        we;
  } wb_t;

  wb_t         sbq[$];
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  logic        m_wbv;
  int          total = 0;
  int          bad = 0;

  cpsr_cond_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_cond(ex_cond), .ex_op(ex_op),
    .ex_setflags(ex_setflags), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_flags(ex_flags),
    .ex_shift_carry(ex_shift_carry), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_result(wb_result), .wb_we(wb_we),
    .cond_pass(cond_pass), .cpsr_flags(cpsr_flags),
    .annul_count(annul_count)
  );

  always #5 clk = ~clk;

  function automatic logic cond_eval(input logic [3:0] cd,
                                     input logic [3:0] f);
    logic v, n, c, z;
    v = f[3]; n = f[2]; c = f[1]; z = f[0];
    if (cd == 4'd0)  return z;
    if (cd == 4'd1)  return ~z;
    if (cd == 4'd2)  return c;
    if (cd == 4'd3)  return ~c;
    if (cd == 4'd4)  return n;
    if (cd == 4'd5)  return ~n;
    if (cd == 4'd6)  return v;
    if (cd == 4'd7)  return ~v;
    if (cd == 4'd8)  return c && !z;
    if (cd == 4'd9)  return !c || z;
    if (cd == 4'd10) return n ~^ v;
    if (cd == 4'd11) return n ^ v;
    if (cd == 4'd12) return !z && (n ~^ v);
    if (cd == 4'd13) return z || (n ^ v);
    if (cd == 4'd14) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_cnt   = 16'd0;
    m_wbv   = 1'b0;
    sbq.delete();
  endtask

  task automatic set_ex(input logic v, input logic [3:0] cd,
                        input logic [4:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] res,
                        input logic [3:0] fl, input logic sc);
    ex_valid = v; ex_cond = cd; ex_op = op; ex_setflags = s;
    ex_rd = rd; ex_result = res; ex_flags = fl; ex_shift_carry = sc;
  endtask

  // One clock: entered just after a negedge with inputs already driven.
  task automatic step();
    logic er, ep, acc, cmp, ar;
    wb_t  e;
    #1;
    er = !m_wbv || wb_ready;
    ep = cond_eval(ex_cond, m_flags);
    total++;
    if (ex_ready !== er) begin
      bad++; $display("FAIL ex_ready got=%b exp=%b", ex_ready, er);
    end
    total++;
    if (cond_pass !== ep) begin
      bad++; $display("FAIL cond_pass cond=%h got=%b exp=%b",
                      ex_cond, cond_pass, ep);
    end
    if (m_wbv) begin
      e = sbq[0];
      total++;
      if (wb_rd !== e.rd || wb_result !== e.res || wb_we !== e.we) begin
        bad++;
        $display("FAIL wb_entry got=%h/%h/%b exp=%h/%h/%b",
                 wb_rd, wb_result, wb_we, e.rd, e.res, e.we);
      end
      if (wb_ready) void'(sbq.pop_front());
    end else begin
      total++;
      if (wb_we !== 1'b0) begin
        bad++; $display("FAIL wb_we_idle got=%b exp=0", wb_we);
      end
    end
    acc = ex_valid && er && !flush;
    cmp = (ex_op >= 5'd8) && (ex_op <= 5'd11);
    ar  = (ex_op == 5'd2) || (ex_op == 5'd3) || (ex_op == 5'd4) ||
          (ex_op == 5'd10) || (ex_op == 5'd11);
    if (acc) begin
      e.rd = ex_rd; e.res = ex_result; e.we = ep && !cmp;
      sbq.push_back(e);
      if (ep && (ex_setflags || cmp))
        m_flags = ar ? ex_flags
                : {m_flags[3], ex_flags[2], ex_shift_carry, ex_flags[0]};
      if (!ep && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      m_wbv = 1'b1;
    end else if (wb_ready) begin
      m_wbv = 1'b0;
    end
    @(posedge clk); #1;
    total++;
    if (cpsr_flags !== m_flags) begin
      bad++; $display("FAIL cpsr_flags got=%b exp=%b", cpsr_flags, m_flags);
    end
    total++;
    if (annul_count !== m_cnt) begin
      bad++; $display("FAIL annul_count got=%h exp=%h", annul_count, m_cnt);
    end
    total++;
    if (wb_valid !== m_wbv) begin
      bad++; $display("FAIL wb_valid got=%b exp=%b", wb_valid, m_wbv);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    set_ex(1'b1, 4'he, 5'd4, 1'b1, 4'd1, 32'h1, 4'hf, 1'b1);
    model_reset();
    @(negedge clk); #1;
    total++;
    if (ex_ready !== 1'b0 || wb_valid !== 1'b0 || wb_we !== 1'b0 ||
        wb_rd !== 4'd0 || wb_result !== 32'd0 ||
        cpsr_flags !== 4'd0 || annul_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state rdy=%b v=%b we=%b rd=%h r=%h f=%b c=%h exp all 0",
               ex_ready, wb_valid, wb_we, wb_rd, wb_result,
               cpsr_flags, annul_count);
    end
    @(negedge clk);
    reset = 1'b0;
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_subs();
    set_ex(1'b1, 4'he, 5'b00010, 1'b1, 4'd3, 32'h0, 4'b0101, 1'b0);
    step();
    total++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 4'd3) begin
      bad++; $display("FAIL subs_wb got=%b/%b/%h exp=1/1/3",
                      wb_valid, wb_we, wb_rd);
    end
    set_ex(1'b1, 4'h0, 5'b00100, 1'b0, 4'd4, 32'h44, 4'b0000, 1'b0);
    #1;
    total++;
    if (cond_pass !== 1'b1) begin
      bad++; $display("FAIL subs_eq got=%b exp=1", cond_pass);
    end
    step();
  endtask

  task automatic test_cmp_ge();
    set_ex(1'b1, 4'he, 5'b01010, 1'b0, 4'd5, 32'h55, 4'b1000, 1'b0);
    step();
    total++;
    if (wb_we !== 1'b0 || cpsr_flags !== 4'b1000) begin
      bad++; $display("FAIL cmp got we=%b f=%b exp we=0 f=1000",
                      wb_we, cpsr_flags);
    end
    set_ex(1'b1, 4'ha, 5'b00100, 1'b1, 4'd6, 32'h66, 4'b0110, 1'b0);
    step();
    total++;
    if (wb_we !== 1'b0 || wb_valid !== 1'b1 || annul_count !== 16'd1) begin
      bad++; $display("FAIL add_ge got we=%b v=%b cnt=%h exp 0/1/1",
                      wb_we, wb_valid, annul_count);
    end
  endtask

  task automatic test_ands();
    set_ex(1'b1, 4'he, 5'b00000, 1'b1, 4'd7, 32'h77, 4'b0100, 1'b1);
    step();
    total++;
    if (cpsr_flags !== 4'b1110) begin
      bad++; $display("FAIL ands_flags got=%b exp=1110", cpsr_flags);
    end
  endtask

  task automatic test_hold();
    logic [31:0] r0;
    wb_ready = 1'b0;
    set_ex(1'b1, 4'he, 5'b00100, 1'b1, 4'd8, 32'h88, 4'b0001, 1'b0);
    r0 = wb_result;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (ex_ready !== 1'b0 || wb_result !== r0) begin
      bad++; $display("FAIL hold got rdy=%b r=%h exp rdy=0 r=%h",
                      ex_ready, wb_result, r0);
    end
    wb_ready = 1'b1;
    step();
    total++;
    if (wb_rd !== 4'd8 || wb_result !== 32'h88) begin
      bad++; $display("FAIL hold_release got=%h/%h exp=8/88",
                      wb_rd, wb_result);
    end
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    set_ex(1'b1, 4'hf, 5'b00010, 1'b1, 4'd9, 32'h99, 4'b1111, 1'b1);
    flush = 1'b1;
    step();
    ex_cond = 4'he;
    step();
    flush = 1'b0;
    ex_valid = 1'b0;
    total++;
    if (wb_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid got=%b exp=0", wb_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      set_ex($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom),
             1'($urandom), 4'($urandom), $urandom, 4'($urandom),
             1'($urandom));
      flush    = ($urandom_range(0, 7) == 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    flush = 1'b0; wb_ready = 1'b1; ex_valid = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    set_ex(1'b1, 4'hf, 5'b00100, 1'b1, 4'd2, 32'h2, 4'b0000, 1'b0);
    for (int i = 0; i < 65536; i++) step();
    total++;
    if (annul_count !== 16'hffff) begin
      bad++; $display("FAIL saturate got=%h exp=ffff", annul_count);
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    set_ex(1'b1, 4'he, 5'b00010, 1'b1, 4'd11, 32'hbeef, 4'b1111, 1'b0);
    step();
    wb_ready = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 4'd0 ||
        wb_result !== 32'd0 || cpsr_flags !== 4'd0 ||
        annul_count !== 16'd0 || ex_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_hold v=%b we=%b rd=%h r=%h f=%b c=%h rdy=%b exp all 0",
               wb_valid, wb_we, wb_rd, wb_result, cpsr_flags,
               annul_count, ex_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    wb_ready = 1'b1;
    ex_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_subs();
    test_cmp_ge();
    test_ands();
    test_hold();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
